// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared ROM geometry, port identifiers and response record for rom_arbiter
package rom_arb_pkg;
    localparam int ROM_AW = 10;
    localparam int ROM_DW = 32;
    typedef enum logic {PORT_FETCH = 1'b0, PORT_LOAD = 1'b1} rom_port_e;
    typedef struct packed {
        logic [ROM_DW-1:0] data;
        logic              err;
    } rom_resp_t;
endpackage

// File: rtl/rom_arb_starve_ctr.sv
// rom_arb_starve_ctr: counts consecutive denied cycles of the load port and raises a one-cycle forced grant at LIM
module rom_arb_starve_ctr #(
    parameter int LIM = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic valid,
    input  logic accepted,
    output logic force_grant
);
    localparam int W = $clog2(LIM + 1) < 1 ? 1 : $clog2(LIM + 1);
    logic [W-1:0] cnt;
    assign force_grant = cnt == W'(LIM);
    always_ff @(posedge clk) begin
        if (rst || !valid || accepted)
            cnt <= '0;
        else if (!force_grant)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: two-port fetch/load arbiter in front of an async-read ROM with registered responses
// Optional load-port starvation guard enabled by defining ROM_ARB_STARVE_GUARD_EN.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int AW          = ROM_AW,
    parameter int DW          = ROM_DW,
    parameter int VALID_WORDS = 1024,
    parameter int STARVE_LIM  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req_valid,
    input  logic [31:0]   req_addr0,
    input  logic [31:0]   req_addr1,
    output logic [1:0]    req_ready,
    output logic [1:0]    resp_valid,
    output logic [DW-1:0] resp_data,
    output logic          resp_err,
    output logic [AW-1:0] rom_address,
    input  logic [DW-1:0] rom_data
);
    logic [1:0]    acc;
    logic [31:0]   sel_addr;
    logic          err;
    logic          force_grant;
    logic [AW-1:0] addr_q;
    logic [1:0]    resp_valid_q;
    rom_resp_t     resp_q;

`ifdef ROM_ARB_STARVE_GUARD_EN
    rom_arb_starve_ctr #(.LIM(STARVE_LIM)) u_starve_ctr (
        .clk         (clk),
        .rst         (rst),
        .valid       (req_valid[PORT_LOAD]),
        .accepted    (acc[PORT_LOAD]),
        .force_grant (force_grant)
    );
`else
    localparam int unused_starve_lim = STARVE_LIM;
    assign force_grant = 1'b0;
`endif

    always_comb begin
        req_ready[PORT_FETCH] = req_valid[PORT_FETCH] & ~(force_grant & req_valid[PORT_LOAD]);
        req_ready[PORT_LOAD]  = req_valid[PORT_LOAD] & (~req_valid[PORT_FETCH] | force_grant);
        acc         = req_valid & req_ready;
        sel_addr    = acc[PORT_LOAD] ? req_addr1 : req_addr0;
        err         = (sel_addr[1:0] != 2'b00) || ({2'b00, sel_addr[31:2]} >= 32'(VALID_WORDS));
        rom_address = |acc ? sel_addr[AW+1:2] : addr_q;
    end

    // The pending response is suppressed while reset is asserted, not only after the reset edge.
    assign resp_valid = rst ? 2'b00 : resp_valid_q;
    assign resp_data  = resp_q.data;
    assign resp_err   = resp_q.err;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= '0;
            resp_valid_q <= '0;
            resp_q       <= '0;
        end else begin
            addr_q       <= rom_address;
            resp_valid_q <= acc;
            if (|acc)
                resp_q <= '{data: err ? '0 : rom_data, err: err};
        end
    end
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed self-checking bench for rom_arbiter with a behavioural ROM model
module tb_rom_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [31:0] req_addr0, req_addr1;
    logic [1:0]  req_ready, resp_valid;
    logic [31:0] resp_data, rom_data;
    logic        resp_err;
    logic [9:0]  rom_address;
    int tests = 0;
    int fails = 0;

    rom_arbiter #(.VALID_WORDS(123), .STARVE_LIM(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_addr0   (req_addr0),
        .req_addr1   (req_addr1),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .resp_err    (resp_err),
        .rom_address (rom_address),
        .rom_data    (rom_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_fn(input logic [9:0] a);
        return {a, 22'h0} ^ 32'h1357_9BDF ^ {22'h0, a};
    endfunction

    assign rom_data = rom_fn(rom_address);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1);
        req_valid = v;
        req_addr0 = a0;
        req_addr1 = a1;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_rdy;
        rst = 1'b1;
        drive(2'b00, 0, 0);
        tick;
        tick;
        rst = 1'b0;
        #1;
        chk("reset_resp_valid", resp_valid, 2'b00);
        chk("reset_resp_data", resp_data, 0);
        chk("reset_resp_err", resp_err, 0);
        chk("reset_rom_address", rom_address, 0);
        chk("reset_req_ready", req_ready, 2'b00);

        drive(2'b01, 32'h8, 0);
        chk("fetch_ready", req_ready, 2'b01);
        chk("fetch_rom_address", rom_address, 2);
        tick;
        chk("fetch_resp_valid", resp_valid, 2'b01);
        chk("fetch_resp_data", resp_data, rom_fn(2));
        chk("fetch_resp_err", resp_err, 0);
        drive(2'b00, 0, 0);
        chk("idle_rom_address_hold", rom_address, 2);

        drive(2'b11, 32'h0, 32'h4);
        chk("contend_ready", req_ready, 2'b01);
        chk("contend_rom_address", rom_address, 0);
        tick;
        chk("contend_resp_valid0", resp_valid, 2'b01);
        chk("contend_resp_data0", resp_data, rom_fn(0));
        drive(2'b10, 32'h0, 32'h4);
        chk("contend_ready1", req_ready, 2'b10);
        chk("contend_rom_address1", rom_address, 1);
        tick;
        chk("contend_resp_valid1", resp_valid, 2'b10);
        chk("contend_resp_data1", resp_data, rom_fn(1));
        chk("contend_resp_err1", resp_err, 0);

        drive(2'b10, 0, 32'h1EC);
        chk("err_range_ready", req_ready, 2'b10);
        tick;
        chk("err_range_valid", resp_valid, 2'b10);
        chk("err_range_err", resp_err, 1);
        chk("err_range_data", resp_data, 0);
        drive(2'b10, 0, 32'h2);
        tick;
        chk("err_misalign_err", resp_err, 1);
        chk("err_misalign_data", resp_data, 0);
        drive(2'b10, 0, 32'h8000_0000);
        tick;
        chk("err_high_err", resp_err, 1);
        drive(2'b10, 0, 32'h1E8);
        tick;
        chk("last_word_err", resp_err, 0);
        chk("last_word_data", resp_data, rom_fn(122));
        drive(2'b00, 0, 0);
        tick;
        chk("idle_resp_valid", resp_valid, 2'b00);
        chk("idle_data_hold", resp_data, rom_fn(122));
        chk("idle_err_hold", resp_err, 0);

        for (int i = 0; i < 123; i++) begin
            req_valid = 2'b01;
            req_addr0 = 32'(i) << 2;
            tick;
            chk("stream_valid", resp_valid, 2'b01);
            chk("stream_data", resp_data, rom_fn(10'(i)));
        end
        drive(2'b00, 0, 0);
        tick;
        chk("stream_end_valid", resp_valid, 2'b00);

        for (int c = 0; c < 10; c++) begin
            drive(2'b11, 32'h10, 32'h20);
`ifdef ROM_ARB_STARVE_GUARD_EN
            exp_rdy = (c % 5 == 4) ? 2'b10 : 2'b01;
`else
            exp_rdy = 2'b01;
`endif
            chk("starve_ready", req_ready, exp_rdy);
            chk("starve_rom_address", rom_address, exp_rdy == 2'b10 ? 10'd8 : 10'd4);
            tick;
            chk("starve_resp_valid", resp_valid, exp_rdy);
        end

        drive(2'b01, 32'hC, 0);
        tick;
        rst = 1'b1;
        drive(2'b00, 0, 0);
        chk("midrst_valid_now", resp_valid, 2'b00);
        tick;
        rst = 1'b0;
        #1;
        chk("midrst_resp_valid", resp_valid, 2'b00);
        chk("midrst_resp_data", resp_data, 0);
        chk("midrst_resp_err", resp_err, 0);
        chk("midrst_rom_address", rom_address, 0);
        tick;
        chk("midrst_after_valid", resp_valid, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-port arbiter that shares the single asynchronous-read instruction/constant ROM (1024 × 32) between the instruction-fetch unit (port 0) and the data-load path (port 1). Each requester presents a byte address with a valid/ready handshake. The arbiter selects one request per cycle, drives the ROM address and returns registered read data one cycle later. It sits between the core's fetch/load units and the ROM instance and is the only ROM address driver.

## Interface
- `AW`, 10: ROM word-address width (1024 words).
- `DW`, 32: ROM data width.
- `VALID_WORDS`, 1024: number of initialized ROM words; word addresses ≥ this value are errors.
- `STARVE_LIM`, 4: consecutive denied cycles on port 1 before a forced grant (used only with the macro).
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 2: per-port request valid (bit 0 = fetch, bit 1 = load).
- `req_addr0`, `req_addr1` in 32: per-port byte address.
- `req_ready` out 2: per-port accept; combinational.
- `resp_valid` out 2: per-port response strobe, one-cycle pulse.
- `resp_data` out DW: registered read data, shared by both ports.
- `resp_err` out 1: registered error flag for the current response.
- `rom_address` out AW: to the ROM address input; combinational.
- `rom_data` in DW: from the ROM asynchronous data output.

## Operation
- **Grant rule (default):** strict priority to port 0.
  - `req_ready[0] = req_valid[0]`.
  - `req_ready[1] = req_valid[1] & ~req_valid[0]`.
- **Accept:** a port is accepted in a cycle where its `req_valid & req_ready` is 1. At most one port is accepted per cycle.
- **ROM address:** `rom_address = sel_addr[AW+1:2]`, where `sel_addr` is the granted port's address. When nothing is granted, `rom_address` holds its last value. After reset it is 0.
- **Error check:** an access is an error if `sel_addr[1:0] != 0` or `sel_addr[31:2] >= VALID_WORDS`.
  - On error, the ROM is not sampled: `resp_data` = 0 and `resp_err` = 1.
- **Response:** in the cycle after an accept, `resp_valid[p]` = 1 for the accepted port, with `resp_data` = the sampled `rom_data` and `resp_err` as computed.
  - In every cycle with no response, `resp_valid` = 0.
  - `resp_data` and `resp_err` hold their last values.
- **No backpressure on responses.** Requesters must capture the response in the strobe cycle.
- **Back-to-back:** one accept per cycle is sustained indefinitely. Responses pipeline with a 1-cycle offset.
- **Request stability:** a requester keeps valid and address stable until it is accepted. The arbiter does not check this.

## Timing
- **Reset values:** `resp_valid` = 0, `resp_data` = 0, `resp_err` = 0, `rom_address` = 0, starvation counter = 0.
- **Latency:** accept in cycle N gives `resp_valid` in cycle N+1. Throughput is 1 access per cycle total.
- **ROM read:** the ROM is combinational; `rom_data` is sampled at the end of the accept cycle.
- **`req_ready`:** depends combinationally on `req_valid` only, never on `resp_*`.
- **Reset mid-operation:** if `rst` is asserted in the cycle after an accept, the pending response is dropped and `resp_valid` stays 0.
- **Simultaneous requests:** when both ports are valid in the same cycle, port 0 wins unless a forced grant is active (see Configuration).

## Configuration
- **`ROM_ARB_STARVE_GUARD_EN` defined:**
  - A counter increments each cycle in which `req_valid[1]` = 1 and port 1 is not accepted.
  - It resets to 0 when port 1 is accepted or `req_valid[1]` = 0.
  - When the counter equals `STARVE_LIM`, port 1 receives the grant in that cycle even if port 0 is valid, and `req_ready[0]` = 0.
  - The forced grant lasts exactly one cycle, after which the counter is 0.
- **Macro undefined:** strict priority. Port 1 may starve indefinitely. No counter logic is present.

## Structure
- **Shared package `rom_arb_pkg`:** constants `ROM_AW` = 10, `ROM_DW` = 32; enum `rom_port_e` {`PORT_FETCH` = 0, `PORT_LOAD` = 1}; response struct {data, err}.
- **Sub-module `rom_arb_starve_ctr`:** the saturating starvation counter with `force_grant` output. It is instantiated only under `ROM_ARB_STARVE_GUARD_EN`.
- The top level contains the grant logic, address mux, error check and response registers. The ROM stays external.

## Test plan
- **Single fetch:** after reset, `req_valid` = 01, `req_addr0` = 0x0000_0008 → `req_ready` = 01 and `rom_address` = 2; next cycle `resp_valid` = 01, `resp_data` = ROM[2], `resp_err` = 0.
- **Contention:** `req_valid` = 11 for 1 cycle with addresses 0x0 and 0x4 → port 0 accepted, `resp_valid` = 01 with ROM[0]; port 1 held and accepted the following cycle with ROM[1], once `req_valid[0]` drops.
- **Errors:** with `VALID_WORDS` = 123:
  - `req_addr1` = 0x0000_01EC (word 123) → `resp_valid` = 10, `resp_err` = 1, `resp_data` = 0.
  - `req_addr1` = 0x0000_0002 (misaligned) → `resp_err` = 1.
- **Streaming:** sweep port 0 over words 0..122 back-to-back → 123 consecutive `resp_valid` = 01 pulses, each `resp_data` equal to the ROM word, no X.
- **Starvation:** with `ROM_ARB_STARVE_GUARD_EN` defined and `STARVE_LIM` = 4, hold `req_valid` = 11 → port 0 accepted for 4 cycles, port 1 in the 5th; repeat with the macro undefined → port 1 never accepted.
- **Reset mid-operation:** accept on port 0, assert `rst` the next cycle → `resp_valid` = 00 and all outputs equal their reset values.
